instruction_exec_md: RTL and testbench

Parametrised next-generation EX stage of the 5-stage MIPS pipeline, sitting between the ID/EX and EX/MEM registers. It keeps the existing behaviour: operand forwarding, ALU-source mux, ALU control, register-destination select and the registered EX/MEM outputs. It adds HI/LO registers and an iterative multiply/divide unit, with a stall output to the hazard unit while that unit is busy. Data width is a parameter.

---
 rtl/instruction_exec_md.sv | 162 ++++++++++++++++
 tb/tb_instruction_exec_md.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_exec_md.sv
// instruction_exec_md: MIPS EX stage with forwarding, ALU, HI/LO and an iterative mult/div unit
module alu #(
  parameter int NB_OP   = 6,
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [4:0]         i_shamt,
  output logic [NB_DATA-1:0] o_result
);
  always_comb begin
    o_result = '0;
    case (i_op)
      6'b000000: o_result = i_b << i_shamt;
      6'b000010: o_result = i_b >> i_shamt;
      6'b000011: o_result = $signed(i_b) >>> i_shamt;
      6'b000100: o_result = i_b << i_a[4:0];
      6'b000110: o_result = i_b >> i_a[4:0];
      6'b000111: o_result = $signed(i_b) >>> i_a[4:0];
      6'b001000, 6'b001001,
      6'b100000, 6'b100001: o_result = i_a + i_b;
      6'b100010, 6'b100011: o_result = i_a - i_b;
      6'b001100, 6'b100100: o_result = i_a & i_b;
      6'b001101, 6'b100101: o_result = i_a | i_b;
      6'b001110, 6'b100110: o_result = i_a ^ i_b;
      6'b100111: o_result = ~(i_a | i_b);
      6'b001010, 6'b101010: o_result = NB_DATA'($signed(i_a) < $signed(i_b));
      6'b001011, 6'b101011: o_result = NB_DATA'(i_a < i_b);
      6'b001111: o_result = i_b << (NB_DATA / 2);
      default: o_result = '0;
    endcase
  end
endmodule

module instruction_exec_md #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic [3:0]         i_ctl_EX,
  input  logic [4:0]         i_ctl_MEM,
  input  logic [1:0]         i_ctl_WB,
  input  logic [NB_DATA-1:0] i_RA,
  input  logic [NB_DATA-1:0] i_RB,
  input  logic [NB_DATA-1:0] i_inmediate,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic [4:0]         i_shamt,
  input  logic [1:0]         i_forward_A,
  input  logic [1:0]         i_forward_B,
  input  logic [NB_DATA-1:0] i_MEM_ALU_result,
  input  logic [NB_DATA-1:0] i_WB_read_data,
  output logic [4:0]         o_ctl_MEM,
  output logic [1:0]         o_ctl_WB,
  output logic [NB_DATA-1:0] o_ALU_result,
  output logic [NB_DATA-1:0] o_data_to_write,
  output logic [NB_REG-1:0]  o_reg_dest,
  output logic [NB_REG-1:0]  o_reg_dest_wire,
  output logic               o_stall
);
  localparam int NB_CNT = $clog2(NB_DATA + 1);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic               reg_dest, alu_src, is_jal, md, md_start, md_div, md_signed, sa, sb;
  logic               is_mfhi, is_mthi, is_mflo, is_mtlo, ge, neg_q, neg_r, div_op;
  logic [1:0]         alu_op, state;
  logic [5:0]         alu_ctl;
  logic [NB_CNT-1:0]  cnt;
  logic [NB_DATA-1:0] fwd_a, fwd_b, alu_b, alu_out, mag_a, mag_b, hi, lo;
  logic [NB_DATA-1:0] acc_hi, acc_lo, opnd, nxt_hi, nxt_lo, fin_hi, fin_lo;
  logic [NB_DATA:0]   sum, shifted, sub;
  logic [2*NB_DATA-1:0] prod;
  assign {reg_dest, alu_src, alu_op} = i_ctl_EX;
  assign is_jal = i_opcode == 6'b000011 || (i_opcode == 6'b0 && i_funct == 6'b001001);
  assign fwd_a = is_jal ? i_RA : i_forward_A == 2'b00 ? i_RA : i_forward_A == 2'b01 ? i_WB_read_data :
                 i_forward_A == 2'b10 ? i_MEM_ALU_result : '0;
  assign fwd_b = is_jal ? i_RB : i_forward_B == 2'b00 ? i_RB : i_forward_B == 2'b01 ? i_WB_read_data :
                 i_forward_B == 2'b10 ? i_MEM_ALU_result : '0;
  assign alu_b = alu_src ? i_inmediate : fwd_b;
  assign alu_ctl = alu_op == 2'b00 ? 6'b100000 : alu_op == 2'b01 ? 6'b111111 : alu_op == 2'b10 ? i_funct : i_opcode;
  assign md = i_opcode == 6'b0 && alu_op == 2'b10;
  assign is_mfhi = md && i_funct == 6'b010000;
  assign is_mthi = md && i_funct == 6'b010001;
  assign is_mflo = md && i_funct == 6'b010010;
  assign is_mtlo = md && i_funct == 6'b010011;
  assign md_start = md && i_funct[5:2] == 4'b0110;
  assign md_div = i_funct[1];
  assign md_signed = !i_funct[0];
  assign sa = md_signed && fwd_a[NB_DATA-1];
  assign sb = md_signed && fwd_b[NB_DATA-1];
  assign mag_a = sa ? -fwd_a : fwd_a;
  assign mag_b = sb ? -fwd_b : fwd_b;
  assign o_stall = (state == IDLE && md_start) || state == BUSY;
  assign o_reg_dest_wire = reg_dest ? i_rd : i_rt;
  alu #(.NB_OP(6), .NB_DATA(NB_DATA)) u_alu (
    .i_a(fwd_a), .i_b(alu_b), .i_op(alu_ctl), .i_shamt(i_shamt), .o_result(alu_out)
  );
  // one shift-add (mult) or restoring-subtract (div) step on {acc_hi, acc_lo}
  assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign shifted = {acc_hi, acc_lo[NB_DATA-1]};
  assign ge = shifted >= {1'b0, opnd};
  assign sub = shifted - {1'b0, opnd};
  assign nxt_hi = div_op ? (ge ? sub[NB_DATA-1:0] : shifted[NB_DATA-1:0]) : sum[NB_DATA:1];
  assign nxt_lo = div_op ? {acc_lo[NB_DATA-2:0], ge} : {sum[0], acc_lo[NB_DATA-1:1]};
  assign prod = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
  assign fin_hi = div_op ? (neg_r ? -nxt_hi : nxt_hi) : prod[2*NB_DATA-1:NB_DATA];
  assign fin_lo = div_op ? (neg_q ? -nxt_lo : nxt_lo) : prod[NB_DATA-1:0];
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd <= '0;
      div_op <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      o_ctl_MEM <= '0;
      o_ctl_WB <= '0;
      o_ALU_result <= '0;
      o_data_to_write <= '0;
      o_reg_dest <= '0;
    end else if (!i_halt) begin
      if (state == IDLE && md_start) begin
        state <= BUSY;
        cnt <= NB_CNT'(NB_DATA);
        acc_hi <= '0;
        acc_lo <= md_div ? mag_a : mag_b;
        opnd <= md_div ? mag_b : mag_a;
        div_op <= md_div;
        // a zero divisor keeps the all-ones quotient unsigned
        neg_q <= (sa ^ sb) && !(md_div && fwd_b == '0);
        neg_r <= sa;
      end else if (state == BUSY) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt <= cnt - NB_CNT'(1);
        if (cnt == NB_CNT'(1)) begin
          hi <= fin_hi;
          lo <= fin_lo;
          state <= DONE;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end else begin
        if (is_mthi) hi <= fwd_a;
        if (is_mtlo) lo <= fwd_a;
      end
      o_ctl_MEM <= o_stall ? '0 : i_ctl_MEM;
      o_ctl_WB <= o_stall ? '0 : {i_ctl_WB[1], i_ctl_WB[0] && state != DONE};
      o_ALU_result <= o_stall ? '0 : is_mfhi ? hi : is_mflo ? lo : alu_out;
      o_data_to_write <= o_stall ? '0 : fwd_b;
      o_reg_dest <= o_stall ? '0 : o_reg_dest_wire;
    end
  end
endmodule

// File: tb/tb_instruction_exec_md.sv
// tb_instruction_exec_md: directed vectors for the EX stage and its mult/div unit
module tb_instruction_exec_md;
  logic        clk = 1'b0;
  logic        i_reset, i_halt;
  logic [3:0]  i_ctl_EX;
  logic [4:0]  i_ctl_MEM;
  logic [1:0]  i_ctl_WB;
  logic [31:0] i_RA, i_RB, i_inmediate, i_MEM_ALU_result, i_WB_read_data;
  logic [4:0]  i_rt, i_rd, i_shamt;
  logic [5:0]  i_opcode, i_funct;
  logic [1:0]  i_forward_A, i_forward_B;
  logic [4:0]  o_ctl_MEM;
  logic [1:0]  o_ctl_WB;
  logic [31:0] o_ALU_result, o_data_to_write;
  logic [4:0]  o_reg_dest, o_reg_dest_wire;
  logic        o_stall;
  int total = 0, bad = 0, cyc;
  logic [31:0] r;

  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;

  instruction_exec_md #(.NB_DATA(32), .NB_REG(5)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_halt(i_halt), .i_ctl_EX(i_ctl_EX), .i_ctl_MEM(i_ctl_MEM),
    .i_ctl_WB(i_ctl_WB), .i_RA(i_RA), .i_RB(i_RB), .i_inmediate(i_inmediate), .i_rt(i_rt), .i_rd(i_rd),
    .i_opcode(i_opcode), .i_funct(i_funct), .i_shamt(i_shamt), .i_forward_A(i_forward_A),
    .i_forward_B(i_forward_B), .i_MEM_ALU_result(i_MEM_ALU_result), .i_WB_read_data(i_WB_read_data),
    .o_ctl_MEM(o_ctl_MEM), .o_ctl_WB(o_ctl_WB), .o_ALU_result(o_ALU_result),
    .o_data_to_write(o_data_to_write), .o_reg_dest(o_reg_dest), .o_reg_dest_wire(o_reg_dest_wire),
    .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    i_ctl_EX = 4'b1010; i_ctl_MEM = 5'b00111; i_ctl_WB = 2'b11;
    i_opcode = 6'b0; i_funct = f; i_RA = a; i_RB = b; i_inmediate = '0;
    i_rt = 5'd2; i_rd = 5'd3; i_shamt = '0; i_forward_A = 2'b00; i_forward_B = 2'b00;
  endtask

  task automatic nop();
    set_r(6'b0, 0, 0);
    i_ctl_EX = 4'b0000; i_ctl_MEM = '0; i_ctl_WB = '0;
  endtask

  task automatic rd(input logic [5:0] f, output logic [31:0] v);
    @(negedge clk);
    set_r(f, 0, 0);
    @(negedge clk);
    v = o_ALU_result;
    nop();
  endtask

  task automatic md_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] fa, input int halt_at, output int n);
    @(negedge clk);
    set_r(f, (fa == 2'b10) ? 32'h1234_5678 : a, b);
    i_forward_A = fa;
    i_MEM_ALU_result = a;
    #1;
    n = 0;
    while (o_stall && n < 200) begin
      if (n == halt_at) i_halt = 1'b1;
      if (n == halt_at + 5) i_halt = 1'b0;
      if (n == 5) begin
        chk("bubble_mem", 32'(o_ctl_MEM), 0);
        chk("bubble_wb", 32'(o_ctl_WB), 0);
      end
      n++;
      @(negedge clk);
      #1;
    end
    i_halt = 1'b0;
    @(negedge clk);
    chk("done_wb", 32'(o_ctl_WB), 32'h2);
    chk("done_mem", 32'(o_ctl_MEM), 32'h7);
    nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_halt = 1'b0; i_MEM_ALU_result = '0; i_WB_read_data = '0;
    nop();
    repeat (3) @(negedge clk);
    chk("rst_alu", o_ALU_result, 0);
    chk("rst_wb", 32'(o_ctl_WB), 0);
    chk("rst_dest", 32'(o_reg_dest), 0);
    chk("rst_stall", 32'(o_stall), 0);
    i_reset = 1'b0;

    md_op(F_MULT, 32'd7, 32'hFFFF_FFFD, 2'b00, -1, cyc);
    chk("mult_stall", cyc, 33);
    rd(F_MFHI, r); chk("mult_hi", r, 32'hFFFF_FFFF);
    rd(F_MFLO, r); chk("mult_lo", r, 32'hFFFF_FFEB);

    md_op(F_MULTU, 32'hFFFF_FFFF, 32'd2, 2'b00, -1, cyc);
    rd(F_MFHI, r); chk("multu_hi", r, 32'h1);
    rd(F_MFLO, r); chk("multu_lo", r, 32'hFFFF_FFFE);

    md_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 2'b00, -1, cyc);
    rd(F_MFLO, r); chk("div_lo", r, 32'hFFFF_FFFD);
    rd(F_MFHI, r); chk("div_hi", r, 32'hFFFF_FFFF);

    md_op(F_DIVU, 32'd9, 32'd0, 2'b00, -1, cyc);
    rd(F_MFLO, r); chk("div0_lo", r, 32'hFFFF_FFFF);
    rd(F_MFHI, r); chk("div0_hi", r, 32'h9);

    md_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, -1, cyc);
    rd(F_MFLO, r); chk("minneg1_lo", r, 32'h8000_0000);
    rd(F_MFHI, r); chk("minneg1_hi", r, 32'h0);

    md_op(F_DIV, 32'd100, 32'd7, 2'b10, -1, cyc);
    rd(F_MFLO, r); chk("divfwd_lo", r, 32'd14);
    rd(F_MFHI, r); chk("divfwd_hi", r, 32'd2);

    md_op(F_MULTU, 32'd6, 32'd7, 2'b00, 10, cyc);
    chk("halt_stall", cyc, 38);
    rd(F_MFLO, r); chk("halt_lo", r, 32'd42);
    rd(F_MFHI, r); chk("halt_hi", r, 32'd0);

    @(negedge clk);
    set_r(F_MULT, 32'd7, 32'd5);
    repeat (4) @(negedge clk);
    i_reset = 1'b1;
    nop();
    @(negedge clk);
    chk("rst_mid_stall", 32'(o_stall), 0);
    i_reset = 1'b0;
    rd(F_MFHI, r); chk("rst_mid_hi", r, 0);
    rd(F_MFLO, r); chk("rst_mid_lo", r, 0);

    @(negedge clk);
    set_r(F_MTLO, 32'h55, 0);
    @(negedge clk);
    set_r(F_MFLO, 0, 0);
    @(negedge clk);
    chk("mtlo_mflo", o_ALU_result, 32'h55);
    chk("mflo_dest", 32'(o_reg_dest), 3);
    set_r(F_MTHI, 32'hA5A5_0001, 0);
    rd(F_MFHI, r); chk("mthi_mfhi", r, 32'hA5A5_0001);

    @(negedge clk);
    set_r(6'b100000, 32'd1, 32'd2);
    i_forward_A = 2'b10; i_MEM_ALU_result = 32'd100;
    i_forward_B = 2'b01; i_WB_read_data = 32'd5;
    #1 chk("dest_wire_rd", 32'(o_reg_dest_wire), 3);
    @(negedge clk);
    chk("add_fwd", o_ALU_result, 32'd105);
    chk("store_data", o_data_to_write, 32'd5);
    chk("add_wb", 32'(o_ctl_WB), 32'h3);
    set_r(6'b100010, 32'd9, 32'd4);
    i_forward_B = 2'b11;
    @(negedge clk);
    chk("sub_fwd_zero", o_ALU_result, 32'd9);
    set_r(6'b0, 32'd10, 32'd77);
    i_ctl_EX = 4'b0111; i_opcode = 6'b001000; i_inmediate = 32'hFFFF_FFFD;
    #1 chk("dest_wire_rt", 32'(o_reg_dest_wire), 2);
    @(negedge clk);
    chk("addi", o_ALU_result, 32'd7);
    chk("addi_store", o_data_to_write, 32'd77);
    set_r(6'b0, 32'h1008, 32'd0);
    i_ctl_EX = 4'b0000; i_opcode = 6'b000011;
    i_forward_A = 2'b10; i_forward_B = 2'b10; i_MEM_ALU_result = 32'd999;
    @(negedge clk);
    chk("jal_nofwd", o_ALU_result, 32'h1008);
    nop();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
